// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// branch_pkg : predictor state encodings and default resolver sizing
// Rev 1.0
// ============================================================================
package branch_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } pred_state_e;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_CNT_W = 16;

    function automatic logic pred_dir(input pred_state_e s);
        return (s == WT) || (s == ST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pred_fifo.sv
`default_nettype none
// ============================================================================
// pred_fifo : DEPTH x 1-bit prediction FIFO with push/pop/flush and count
// Rev 1.0
// ============================================================================
module pred_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   din_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic                   dout_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    // Pointers are AW bits wide, so wrap modulo DEPTH is implicit.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_i && !pop_i)      count_d = count_q + 1'b1;
            else if (!push_i && pop_i) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
// branch_resolver : tracks predicted branches, resolves in order, flushes on
// mispredict. Optional statistics counters via BRANCH_RESOLVER_STATS_EN.
// Rev 1.0
// ============================================================================
module branch_resolver
    import branch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fetch_valid,
    output logic                   fetch_ready,
    output logic                   pred_request,
    input  logic                   prediction,
    input  logic                   outcome_valid,
    input  logic                   outcome_taken,
    output logic                   outcome_ready,
    output logic                   result,
    output logic                   taken,
    output logic                   mispredict,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [CNT_W-1:0]       branch_count,
    output logic [CNT_W-1:0]       mispredict_count
);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             pending_q, pending_d;
    logic             result_q, result_d;
    logic             taken_q, taken_d;
    logic             mispredict_q, mispredict_d;

    logic             w_head;
    logic             w_empty;
    logic [OCC_W-1:0] w_count;
    logic             w_pop;
    logic             w_miss;
    logic             w_push;

    pred_fifo #(
        .DEPTH (DEPTH)
    ) u_pred_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .din_i   (prediction),
        .pop_i   (w_pop),
        .flush_i (w_miss),
        .dout_o  (w_head),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    // Pending capture counts toward occupancy so the FIFO can never overflow.
    assign occupancy     = w_count + OCC_W'(pending_q);
    assign fetch_ready   = (occupancy < OCC_W'(DEPTH));
    assign pred_request  = rst_n && fetch_valid && fetch_ready;
    assign outcome_ready = !w_empty;

    assign w_pop  = outcome_valid && outcome_ready;
    assign w_miss = w_pop && (w_head != outcome_taken);
    assign w_push = pending_q && !w_miss;

    always_comb begin
        pending_d    = pred_request && !w_miss;
        result_d     = w_pop;
        taken_d      = w_pop && outcome_taken;
        mispredict_d = w_miss;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q    <= 1'b0;
            result_q     <= 1'b0;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            result_q     <= result_d;
            taken_q      <= taken_d;
            mispredict_q <= mispredict_d;
        end
    end

    assign result     = result_q;
    assign taken      = taken_q;
    assign mispredict = mispredict_q;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    // Both counters saturate at all-ones.
    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (w_pop && (branch_count_q != '1))
            branch_count_d = branch_count_q + 1'b1;
        if (w_miss && (mispredict_count_q != '1))
            mispredict_count_d = mispredict_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
`else
    assign branch_count     = '0;
    assign mispredict_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// ============================================================================
// tb_branch_resolver : directed table plus randomized run against a queue model
// Rev 1.0
// ============================================================================
module tb_branch_resolver;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef BRANCH_RESOLVER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             fetch_valid;
    logic             fetch_ready;
    logic             pred_request;
    logic             prediction;
    logic             outcome_valid;
    logic             outcome_taken;
    logic             outcome_ready;
    logic             result;
    logic             taken;
    logic             mispredict;
    logic [2:0]       occupancy;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    branch_resolver #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_valid      (fetch_valid),
        .fetch_ready      (fetch_ready),
        .pred_request     (pred_request),
        .prediction       (prediction),
        .outcome_valid    (outcome_valid),
        .outcome_taken    (outcome_taken),
        .outcome_ready    (outcome_ready),
        .result           (result),
        .taken            (taken),
        .mispredict       (mispredict),
        .occupancy        (occupancy),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rn, fv, pd, ov, ot;
        int occ, fr, ordy, res, tk, mis;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of captured predictions plus one pending capture.
    bit mq[$];
    bit mpend;
    bit e_res, e_tk, e_mis;
    int e_br, e_mc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpend = 1'b0;
        e_res = 1'b0; e_tk = 1'b0; e_mis = 1'b0;
        e_br  = 0;    e_mc = 0;
    endtask

    function automatic vec_t mk(input int rn, fv, pd, ov, ot);
        vec_t v;
        v = '{rn, fv, pd, ov, ot, 0, 0, 0, 0, 0, 0};
        return v;
    endfunction

    task automatic cycle(input vec_t v, input bit use_tbl, input int idx);
        int  inflight;
        bit  acc, pop, head, miss;
        rst_n         = v.rn[0];
        fetch_valid   = v.fv[0];
        prediction    = v.pd[0];
        outcome_valid = v.ov[0];
        outcome_taken = v.ot[0];
        @(negedge clk);
        inflight = mq.size() + int'(mpend);
        chk("fetch_ready",      32'(fetch_ready),      32'(inflight < DEPTH));
        chk("pred_request",     32'(pred_request),     32'(v.rn != 0 && v.fv != 0 && inflight < DEPTH));
        chk("outcome_ready",    32'(outcome_ready),    32'(mq.size() > 0));
        chk("occupancy",        32'(occupancy),        32'(inflight));
        chk("result",           32'(result),           32'(e_res));
        chk("taken",            32'(taken),            32'(e_tk));
        chk("mispredict",       32'(mispredict),       32'(e_mis));
        chk("branch_count",     32'(branch_count),     STATS ? 32'(e_br) : 32'd0);
        chk("mispredict_count", 32'(mispredict_count), STATS ? 32'(e_mc) : 32'd0);
        if (use_tbl) begin
            chk($sformatf("tbl%0d.occupancy", idx),     32'(occupancy),     32'(v.occ));
            chk($sformatf("tbl%0d.fetch_ready", idx),   32'(fetch_ready),   32'(v.fr));
            chk($sformatf("tbl%0d.outcome_ready", idx), 32'(outcome_ready), 32'(v.ordy));
            chk($sformatf("tbl%0d.result", idx),        32'(result),        32'(v.res));
            chk($sformatf("tbl%0d.taken", idx),         32'(taken),         32'(v.tk));
            chk($sformatf("tbl%0d.mispredict", idx),    32'(mispredict),    32'(v.mis));
        end
        if (v.rn == 0) begin
            model_reset();
        end else begin
            acc  = (v.fv != 0) && (inflight < DEPTH);
            pop  = (v.ov != 0) && (mq.size() > 0);
            miss = 1'b0;
            e_res = pop; e_tk = pop && (v.ot != 0); e_mis = 1'b0;
            if (pop) begin
                head = mq.pop_front();
                miss = (head != v.ot[0]);
                e_mis = miss;
                if (e_br < MAXC) e_br++;
                if (miss && e_mc < MAXC) e_mc++;
            end
            if (miss) begin
                mq.delete();
                mpend = 1'b0;
            end else begin
                if (mpend) mq.push_back(v.pd[0]);
                mpend = acc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[37];
    vec_t rv;

    initial begin
        //          rn fv pd ov ot  occ fr or res tk mis
        tbl[ 0] = '{0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0};
        tbl[ 1] = '{1, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0};
        tbl[ 2] = '{1, 0, 1, 0, 0,  1, 1, 0, 0, 0, 0};
        tbl[ 3] = '{1, 0, 0, 1, 1,  1, 1, 1, 0, 0, 0};
        tbl[ 4] = '{1, 0, 0, 0, 0,  0, 1, 0, 1, 1, 0};
        tbl[ 5] = '{1, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0};
        tbl[ 6] = '{1, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0};
        tbl[ 7] = '{1, 1, 0, 0, 0,  2, 1, 1, 0, 0, 0};
        tbl[ 8] = '{1, 1, 1, 0, 0,  3, 1, 1, 0, 0, 0};
        tbl[ 9] = '{1, 1, 0, 0, 0,  4, 0, 1, 0, 0, 0};
        tbl[10] = '{1, 1, 0, 0, 0,  4, 0, 1, 0, 0, 0};
        tbl[11] = '{1, 1, 0, 1, 1,  4, 0, 1, 0, 0, 0};
        tbl[12] = '{1, 0, 0, 1, 0,  3, 1, 1, 1, 1, 0};
        tbl[13] = '{1, 0, 0, 1, 1,  2, 1, 1, 1, 0, 0};
        tbl[14] = '{1, 0, 0, 1, 0,  1, 1, 1, 1, 1, 0};
        tbl[15] = '{1, 0, 0, 1, 1,  0, 1, 0, 1, 0, 0};
        tbl[16] = '{1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0};
        tbl[17] = '{1, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0};
        tbl[18] = '{1, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0};
        tbl[19] = '{1, 1, 1, 0, 0,  2, 1, 1, 0, 0, 0};
        tbl[20] = '{1, 0, 0, 0, 0,  3, 1, 1, 0, 0, 0};
        tbl[21] = '{1, 1, 0, 1, 0,  3, 1, 1, 0, 0, 0};
        tbl[22] = '{1, 0, 0, 1, 1,  0, 1, 0, 1, 0, 1};
        tbl[23] = '{1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0};
        tbl[24] = '{1, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0};
        tbl[25] = '{1, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0};
        tbl[26] = '{1, 1, 0, 1, 1,  2, 1, 1, 0, 0, 0};
        tbl[27] = '{1, 0, 1, 0, 0,  2, 1, 1, 1, 1, 0};
        tbl[28] = '{1, 0, 0, 1, 0,  2, 1, 1, 0, 0, 0};
        tbl[29] = '{1, 0, 0, 1, 1,  1, 1, 1, 1, 0, 0};
        tbl[30] = '{1, 0, 0, 0, 0,  0, 1, 0, 1, 1, 0};
        tbl[31] = '{1, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0};
        tbl[32] = '{1, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0};
        tbl[33] = '{1, 1, 1, 0, 0,  2, 1, 1, 0, 0, 0};
        tbl[34] = '{0, 1, 0, 0, 0,  3, 1, 1, 0, 0, 0};
        tbl[35] = '{1, 0, 1, 0, 0,  0, 1, 0, 0, 0, 0};
        tbl[36] = '{1, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0};

        rst_n = 1'b0; fetch_valid = 1'b0; prediction = 1'b0;
        outcome_valid = 1'b0; outcome_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        for (int i = 0; i < 37; i++) cycle(tbl[i], 1'b1, i);

        // Five mispredicting resolves drive both counters into saturation.
        for (int k = 0; k < 5; k++) begin
            cycle(mk(1, 1, 0, 0, 0), 1'b0, 0);
            cycle(mk(1, 0, 1, 0, 0), 1'b0, 0);
            cycle(mk(1, 0, 0, 1, 0), 1'b0, 0);
            cycle(mk(1, 0, 0, 0, 0), 1'b0, 0);
        end
        @(negedge clk);
        chk("sat.branch_count",     32'(branch_count),     STATS ? 32'd3 : 32'd0);
        chk("sat.mispredict_count", 32'(mispredict_count), STATS ? 32'd3 : 32'd0);
        @(posedge clk);
        #1;

        for (int n = 0; n < 3000; n++) begin
            rv = mk(($urandom_range(0, 199) != 0) ? 1 : 0,
                    ($urandom_range(0, 9) < 7) ? 1 : 0,
                    int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 1)));
            if (mq.size() > 0 && $urandom_range(0, 4) != 0) rv.ot = int'(mq[0]);
            cycle(rv, 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL provide parameter DEPTH, default 4: maximum outstanding (predicted, unresolved) branches; power of two, 2..16.
REQ-002 SHALL provide parameter CNT_W, default 16: width of each statistics counter.
REQ-003 SHALL have one clock and a synchronous, active-low reset: clk is the clock; rst_n is the reset, sampled on posedge clk.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 fetch_valid  input  1  a new branch needs a prediction this cycle.
REQ-007 fetch_ready  output  1  a branch can be accepted this cycle.
REQ-008 pred_request  output  1  prediction request to the predictor.
REQ-009 prediction  input  1  predictor answer, valid the cycle after pred_request.
REQ-010 outcome_valid  input  1  the oldest branch has resolved this cycle.
REQ-011 outcome_taken  input  1  actual direction of the resolved branch.
REQ-012 outcome_ready  output  1  a captured prediction is available to resolve.
REQ-013 result  output  1  predictor training strobe.
REQ-014 taken  output  1  actual direction for training.
REQ-015 mispredict  output  1  one-cycle flush pulse.
REQ-016 occupancy  output  $clog2(DEPTH)+1  in-flight count (captured plus capture-pending).
REQ-017 branch_count, mispredict_count  output  CNT_W each  statistics (see Configuration).

Function
REQ-018 Accept condition: fetch_ready = (occupancy < DEPTH); pred_request = fetch_valid && fetch_ready, combinational, same cycle.
REQ-019 Capture latency: the cycle after an accept, the prediction input is pushed into the FIFO; the entry is counted in occupancy from the accept edge onward.
REQ-020 Resolve condition: outcome_ready = (FIFO non-empty), counting captured entries only; outcome_valid while outcome_ready=0 SHALL be ignored.
REQ-021 Resolve action: on outcome_valid && outcome_ready, pop the oldest entry; the next cycle, drive result=1 and taken=outcome_taken for exactly one cycle.
REQ-022 Mispredict: if the popped prediction != outcome_taken, assert mispredict=1 in the same registered cycle as result.
REQ-023 Mispredict flush: on a mispredicting resolve, discard all younger entries, the same-cycle accept, and any capture pending in that cycle; occupancy becomes 0 next cycle.
REQ-024 Simultaneous accept, capture and correct resolve: all proceed, and occupancy changes by (+accept - pop).
REQ-025 Full FIFO plus a same-cycle pop: fetch_ready stays 0 that cycle; there is no bypass.
REQ-026 FIFO pointers wrap modulo DEPTH, and order SHALL be strictly FIFO.
REQ-027 result, taken and mispredict SHALL be registered outputs and are 0 in every cycle without a resolve.

Reset
REQ-028 While rst_n=0 at posedge clk: FIFO empty, occupancy=0, capture-pending cleared, result=0, taken=0, mispredict=0, counters=0.
REQ-029 Reset mid-operation discards all in-flight entries; a prediction arriving the cycle after reset SHALL be ignored.
REQ-030 pred_request SHALL be 0 while rst_n=0.

Configuration
REQ-031 Macro BRANCH_RESOLVER_STATS_EN defined: branch_count increments on each resolve, and mispredict_count increments on each mispredict.
REQ-032 With BRANCH_RESOLVER_STATS_EN defined, both counters saturate at 2^CNT_W-1.
REQ-033 Macro undefined: both counters are tied to 0, with no counter flops.

Structure
REQ-034 Shared package branch_pkg SHALL hold the 2-bit predictor state encodings (SNT=0, WNT=1, WT=2, ST=3) and the default DEPTH and CNT_W constants.
REQ-035 One sub-module, pred_fifo (DEPTH x 1-bit, push/pop/flush, count), SHALL be instantiated.
REQ-036 Accept, capture, resolve and statistics logic SHALL reside in branch_resolver.

Verification
REQ-037 Single branch: accept at cycle 0, prediction=1 at cycle 1, outcome_valid=1 with taken=1 at cycle 3 -> result=1, taken=1, mispredict=0 at cycle 4; occupancy returns to 0.
REQ-038 Full: 4 accepts back-to-back with no resolves -> fetch_ready=0 and occupancy=4; one correct resolve -> fetch_ready=1 the next cycle.
REQ-039 Mispredict flush: 3 captured entries with predictions 1,1,0; outcome_taken=0 resolves the oldest -> mispredict=1, taken=0, occupancy=0 next cycle; next resolve ignored (outcome_ready=0).
REQ-040 Simultaneous events: a correct resolve in the same cycle as an accept and a capture, with occupancy=2 -> occupancy=2 afterwards, order preserved.
REQ-041 Reset mid-operation: rst_n=0 for one cycle with occupancy=3 -> all outputs 0, and a stale prediction the next cycle is not pushed.
REQ-042 Statistics, with BRANCH_RESOLVER_STATS_EN and CNT_W=2: 5 mispredicting resolves -> mispredict_count=3 (saturated) and branch_count=3; without the macro, both read 0.
